// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and range helpers for the programmable up/down modulo counter.
package updown_mod_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int unsigned clamp_range(input int unsigned value,
                                              input int unsigned min_v,
                                              input int unsigned max_v);
    if (value > max_v)
      return max_v;
    else if (value < min_v)
      return min_v;
    else
      return value;
  endfunction

  // A step equal to the range is kept as-is; it wraps back onto the same count.
  function automatic int unsigned mod_step(input int unsigned step_v,
                                           input int unsigned range_v);
    if (step_v > range_v)
      return step_v % range_v;
    else
      return step_v;
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle between a counter and whatever drives it.
interface updown_mod_counter_if #(
  parameter int WIDTH  = 9,
  parameter int STEP_W = 4
);
  logic              enable;
  logic              updown;
  logic [STEP_W-1:0] step;
  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  count;
  logic              carry;
  logic              at_max;
  logic              at_min;

  modport master (
    output enable, updown, step, clear, load, load_val,
    input  count, carry, at_max, at_min
  );

  modport slave (
    input  enable, updown, step, clear, load, load_val,
    output count, carry, at_max, at_min
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over [MIN..MAX] with variable step, load/clear, wrap or saturate,
// and a registered carry pulse for chaining.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int MIN       = 0,
  parameter int MAX       = 479,
  parameter int RESET_VAL = 0,
  parameter int STEP_W    = 4,
  parameter int SATURATE  = 0
) (
  input logic                clk,
  input logic                reset,
  updown_mod_counter_if.slave bus
);

  localparam int IW    = WIDTH + 2;
  localparam int RANGE = MAX - MIN + 1;

  localparam logic [IW-1:0]    MIN_I   = IW'(MIN);
  localparam logic [IW-1:0]    MAX_I   = IW'(MAX);
  localparam logic [IW-1:0]    RANGE_I = IW'(RANGE);
  localparam logic [IW-1:0]    RST_I   = IW'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic [IW-1:0]    cur;
  logic [IW-1:0]    step_eff;
  logic [IW-1:0]    up_sum;
  logic [IW-1:0]    nxt;
  logic             nxt_carry;

  assign cur      = {2'b00, count_q};
  assign step_eff = IW'(mod_step(32'(bus.step), RANGE));
  assign up_sum   = cur + step_eff;

  always_comb begin
    nxt       = cur;
    nxt_carry = 1'b0;
    if (bus.clear) begin
      nxt = RST_I;
    end else if (bus.load) begin
      nxt = IW'(clamp_range(32'(bus.load_val), MIN, MAX));
    end else if (bus.enable) begin
      if (bus.updown) begin
        if (up_sum > MAX_I) begin
          if (SATURATE == MODE_SAT) begin
            nxt       = MAX_I;
            nxt_carry = (cur != MAX_I);
          end else begin
            nxt       = up_sum - RANGE_I;
            nxt_carry = 1'b1;
          end
        end else begin
          nxt = up_sum;
        end
      end else begin
        // Compare as cur < MIN + step so the unsigned subtraction never underflows.
        if (cur < MIN_I + step_eff) begin
          if (SATURATE == MODE_SAT) begin
            nxt       = MIN_I;
            nxt_carry = (cur != MIN_I);
          end else begin
            nxt       = cur + RANGE_I - step_eff;
            nxt_carry = 1'b1;
          end
        end else begin
          nxt = cur - step_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_W;
      carry_q <= 1'b0;
    end else begin
      count_q <= WIDTH'(nxt);
      carry_q <= nxt_carry;
    end
  end

  assign bus.count  = count_q;
  assign bus.carry  = carry_q;
  assign bus.at_max = (count_q == WIDTH'(MAX));
  assign bus.at_min = (count_q == WIDTH'(MIN));

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised up/down counter over a programmable range [MIN..MAX], with variable step, synchronous load and clear, and wrap or saturate mode.
- Emits a registered carry/borrow pulse so instances can be chained, e.g. pixel column into line counter for the VGA timing path.
- Successor to the fixed-range 9-bit counter used for display timing; replaces ad-hoc per-use counters.

Parameters:
- WIDTH, 9, count register width in bits.
- MIN, 0, lowest legal count value.
- MAX, 479, highest legal count value; MIN < MAX < 2**WIDTH.
- RESET_VAL, 0, value loaded on reset; must lie in [MIN..MAX].
- STEP_W, 4, width of the step input.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  async active-high reset.
- enable  input  1  count-advance qualifier.
- updown  input  1  1 = count up, 0 = count down.
- step  input  STEP_W  increment magnitude per enabled cycle.
- clear  input  1  sync return to RESET_VAL.
- load  input  1  sync load of load_val.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  current count, registered.
- carry  output  1  registered one-cycle pulse on wrap or saturation hit.
- at_max  output  1  comb, count == MAX.
- at_min  output  1  comb, count == MIN.

Behaviour:
- One clock domain (clk). Async active-high reset: count = RESET_VAL, carry = 0, asserted immediately and independent of clk.
- Priority per rising edge: clear > load > enable. Lower-priority requests in the same cycle are ignored.
- clear: count <= RESET_VAL, carry <= 0.
- load: count <= load_val clamped to [MIN..MAX], so above MAX loads MAX and below MIN loads MIN. carry <= 0.
- enable=0, or enable=1 with step=0: count holds, carry <= 0.
- Arithmetic: all intermediates are WIDTH+2 bits unsigned; no overflow of the intermediate is permitted. RANGE = MAX-MIN+1.
- step > RANGE is treated as step mod RANGE (reduced combinationally).
- Up (updown=1), next = count + step:
  - next <= MAX: count <= next, carry <= 0.
  - next > MAX, SATURATE=0: count <= next - RANGE, carry <= 1.
  - next > MAX, SATURATE=1: count <= MAX, carry <= 1 only if count != MAX beforehand.
- Down (updown=0), mirrored at MIN:
  - count - step < MIN, wrap mode: count <= count - step + RANGE, carry <= 1.
  - Saturate mode: count <= MIN, carry pulses once on arrival.
- carry is high for exactly the cycle after the causing edge and never stays high two cycles unless consecutive enabled steps each wrap.
- Direction may change on any cycle with no dead cycle.
- at_max and at_min are decoded from the count register, with no extra latency.
- Reset mid-count: count returns to RESET_VAL immediately; any pending carry is cleared.
- Range restriction: count never leaves [MIN..MAX] after reset.

Decomposition:
- Shared package holds:
  - localparam mode codes MODE_WRAP=0, MODE_SAT=1;
  - function clamp_range(value, MIN, MAX);
  - function mod_step(step, RANGE).
- No sub-module needed. The next-state adder/compare may be split into a combinational helper, updown_mod_next, if synthesis timing requires; the default is a single module.

Test Plan (MIN=0, MAX=479, RESET_VAL=0, STEP_W=4 unless stated):
- Reset, then 480 enabled cycles with updown=1, step=1 -> count 0..479, then 0; carry high exactly one cycle after the 479->0 edge; at_max high only at 479.
- Down from 0, step=1 -> count 479 next cycle, carry=1 for one cycle; at_min high at 0 only.
- Wrap with large step: load 475, step=7, up -> count 2, carry=1. Then step=0 -> count holds at 2, carry=0.
- SATURATE=1, load 470, step=5, up for 3 cycles -> 475, 479, 479; carry pulses once, on the 475->479 edge.
- Priority: clear=1, load=1, load_val=300, enable=1 on the same edge -> count 0. Next cycle load only with load_val=500 -> count 479 (clamped).
- Async reset asserted mid-cycle while count=250 -> count=0 and carry=0 before the next clk edge; counting resumes on the first edge after reset deasserts.
